// File: rtl/rle_pkg.sv
// Shared run-length frame format and decoder state encoding.
// The rle encoder imports this same package so both sides agree on the entry layout.
package rle_pkg;

  localparam int ENTRY_W   = 16;
  localparam int COUNT_W   = 8;
  localparam int BYTE_W    = 8;
  localparam int COUNT_LSB = 0;
  localparam int BYTE_LSB  = 8;

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_EXPAND,
    S_WRITE,
    S_FLUSH
  } state_t;

  function automatic logic [COUNT_W-1:0] entry_count(input entry_t e);
    return e[COUNT_LSB +: COUNT_W];
  endfunction

  function automatic logic [BYTE_W-1:0] entry_byte(input entry_t e);
    return e[BYTE_LSB +: BYTE_W];
  endfunction

endpackage

// File: rtl/rle_decode_if.sv
// Port-A SRAM bus shared by the rle encoder and decoder.
// The master is the codec; the slave is the SRAM.
interface rle_decode_if #(
  parameter int ADDR_W = 16
);
  logic              port_A_clk;
  logic [ADDR_W-1:0] port_A_addr;
  logic              port_A_we;
  logic [31:0]       port_A_data_in;
  logic [31:0]       port_A_data_out;

  modport master (
    output port_A_clk, port_A_addr, port_A_we, port_A_data_in,
    input  port_A_data_out
  );

  modport slave (
    input  port_A_clk, port_A_addr, port_A_we, port_A_data_in,
    output port_A_data_out
  );
endinterface

// File: rtl/rle_byte_packer.sv
// Packs bytes little-endian into a 32-bit word; lane 0 is filled first.
// Clearing zeroes the word so a partial word carries zero upper lanes.
module rle_byte_packer
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic [BYTE_W-1:0] value,
  input  logic              valid,
  input  logic              clear,
  output logic [31:0]       word,
  output logic [2:0]        fill,
  output logic              full
);

  assign full = (fill == 3'd4);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      word <= '0;
      fill <= '0;
    end else if (clear) begin
      word <= '0;
      fill <= '0;
    end else if (valid && !full) begin
      word[{fill[1:0], 3'b000} +: BYTE_W] <= value;
      fill                                <= fill + 3'd1;
    end
  end

endmodule

// File: rtl/rle_decode.sv
// Run-length decoder: reads {byte, count} entries over port A, expands them,
// and writes the plaintext back as little-endian 32-bit words.
module rle_decode
  import rle_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [31:0] rle_addr,
  input  logic [31:0] rle_size,
  input  logic [31:0] message_addr,
  output logic [31:0] message_size,
  output logic        done,
  rle_decode_if.master port_a
);

  state_t            state, state_d, ret_state, ret_d, next_run;
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [31:0]       size_q, consumed, byte_cnt, word_q;
  logic              entry_sel;
  logic [COUNT_W-1:0] remaining;

  logic accept, zero_frame, emit, ent_end, word_done, flush_wr, pk_clear;
  logic [BYTE_W-1:0] pk_value;
  logic [31:0]       pk_word;
  logic [2:0]        pk_fill;
  logic              pk_full;

  assign pk_value = entry_sel ? entry_byte(word_q[2*ENTRY_W-1:ENTRY_W])
                              : entry_byte(word_q[ENTRY_W-1:0]);

  rle_byte_packer u_packer (
    .clk    (clk),
    .nreset (nreset),
    .value  (pk_value),
    .valid  (emit),
    .clear  (pk_clear),
    .word   (pk_word),
    .fill   (pk_fill),
    .full   (pk_full)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
    end else begin
      state     <= state_d;
      ret_state <= ret_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state;
    ret_d      = ret_state;
    next_run   = S_EXPAND;
    accept     = 1'b0;
    zero_frame = 1'b0;
    emit       = 1'b0;
    ent_end    = 1'b0;
    word_done  = 1'b0;
    flush_wr   = 1'b0;
    pk_clear   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          pk_clear = 1'b1;
          if (rle_size == 32'd0) zero_frame = 1'b1;
          else                   state_d    = S_RD_ADDR;
        end
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: state_d = S_EXPAND;
      S_EXPAND: begin
        emit      = (remaining != '0) && !pk_full;
        ent_end   = (remaining == '0) || (emit && remaining == COUNT_W'(1));
        word_done = emit && (pk_fill == 3'd3);
        if (ent_end && entry_sel)
          next_run = (consumed < size_q) ? S_RD_ADDR : S_FLUSH;
        // A completed word detours through WRITE, then resumes where the run left off.
        flush_wr = (next_run == S_FLUSH) && !word_done && ((pk_fill != 3'd0) || emit);
        if (word_done) begin
          state_d = S_WRITE;
          ret_d   = next_run;
        end else begin
          state_d = next_run;
        end
      end
      S_WRITE: begin
        state_d  = ret_state;
        pk_clear = 1'b1;
      end
      S_FLUSH: begin
        state_d  = S_IDLE;
        pk_clear = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port-A controls are registered from the next state so they are valid for the whole cycle.
  assign port_a.port_A_clk     = clk;
  assign port_a.port_A_data_in = pk_word;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      port_a.port_A_addr <= '0;
      port_a.port_A_we   <= 1'b0;
    end else begin
      port_a.port_A_we <= 1'b0;
      if (state_d == S_RD_ADDR) begin
        port_a.port_A_addr <= (state == S_IDLE) ? rle_addr[ADDR_W-1:0] : rd_ptr;
      end else if (state_d == S_WRITE || flush_wr) begin
        port_a.port_A_addr <= wr_ptr;
        port_a.port_A_we   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      size_q       <= '0;
      consumed     <= '0;
      byte_cnt     <= '0;
      word_q       <= '0;
      entry_sel    <= 1'b0;
      remaining    <= '0;
      done         <= 1'b0;
      message_size <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rd_ptr       <= rle_addr[ADDR_W-1:0];
            wr_ptr       <= message_addr[ADDR_W-1:0];
            size_q       <= rle_size;
            consumed     <= '0;
            byte_cnt     <= '0;
            done         <= zero_frame;
            message_size <= '0;
          end
        end
        S_RD_DATA: begin
          word_q    <= port_a.port_A_data_out;
          entry_sel <= 1'b0;
          remaining <= entry_count(port_a.port_A_data_out[ENTRY_W-1:0]);
          rd_ptr    <= rd_ptr + ADDR_W'(4);
          consumed  <= consumed + 32'd4;
        end
        S_EXPAND: begin
          if (emit) byte_cnt <= byte_cnt + 32'd1;
          if (ent_end && !entry_sel) begin
            entry_sel <= 1'b1;
            remaining <= entry_count(word_q[2*ENTRY_W-1:ENTRY_W]);
          end else if (emit) begin
            remaining <= remaining - COUNT_W'(1);
          end
        end
        S_WRITE: wr_ptr <= wr_ptr + ADDR_W'(4);
        S_FLUSH: begin
          done         <= 1'b1;
          message_size <= byte_cnt;
        end
        default: ;
      endcase
    end
  end

  // Address bits above ADDR_W and entry 0's count (taken straight from the bus) are not needed.
  logic unused_bits;
  assign unused_bits = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W], word_q[COUNT_W-1:0]};

endmodule

// File: tb/tb_rle_decode.sv
// Self-checking bench for rle_decode: an SRAM model serves frames and a
// scoreboard of expected writes is checked as the decoder writes them.
module tb_rle_decode;

  localparam int ADDR_W = 16;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start;
  logic [31:0] rle_addr, rle_size, message_addr;
  logic [31:0] message_size;
  logic        done;

  rle_decode_if #(.ADDR_W(ADDR_W)) port_a ();

  rle_decode #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .start        (start),
    .rle_addr     (rle_addr),
    .rle_size     (rle_size),
    .message_addr (message_addr),
    .message_size (message_size),
    .done         (done),
    .port_a       (port_a)
  );

  always #5 clk = ~clk;

  // Source region only; decoder writes go to the scoreboard rather than memory.
  logic [31:0] rd_mem [0:16383];
  always @(posedge port_a.port_A_clk)
    if (!port_a.port_A_we) port_a.port_A_data_out <= rd_mem[port_a.port_A_addr[15:2]];

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         exp_e;
  logic [31:0] frame_w[$];
  int          exp_size;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          sb_ignore = 1'b0;
  logic        prev_we   = 1'b0;

  always @(negedge clk) begin
    if (nreset && port_a.port_A_we) begin
      n_checks++;
      if (prev_we) begin
        n_fail++;
        $display("FAIL we_pulse: we high on consecutive cycles at addr %h, required single-cycle pulses",
                 port_a.port_A_addr);
      end
      if (!sb_ignore) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write",
                   port_a.port_A_addr, port_a.port_A_data_in);
        end else begin
          exp_e = exp_q.pop_front();
          if (port_a.port_A_addr !== exp_e.addr || port_a.port_A_data_in !== exp_e.data) begin
            n_fail++;
            $display("FAIL write: got addr %h data %h, required addr %h data %h",
                     port_a.port_A_addr, port_a.port_A_data_in, exp_e.addr, exp_e.data);
          end
        end
      end
    end
    prev_we = nreset && port_a.port_A_we;
  end

  task automatic load_frame(input logic [15:0] src);
    for (int i = 0; i < frame_w.size(); i++) rd_mem[src[15:2] + 14'(i)] = frame_w[i];
  endtask

  // Expands frame_w into a plain byte list, then packs that list into expected writes.
  task automatic build_expect(input logic [15:0] dst, input int nwords);
    logic [7:0]  b[$];
    logic [15:0] en;
    logic [31:0] d;
    b = {};
    for (int w = 0; w < nwords; w++) begin
      for (int h = 0; h < 2; h++) begin
        en = (h == 0) ? frame_w[w][15:0] : frame_w[w][31:16];
        for (int c = 0; c < int'(en[7:0]); c++) b.push_back(en[15:8]);
      end
    end
    for (int i = 0; i < b.size(); i += 4) begin
      d = '0;
      for (int k = 0; k < 4; k++) if (i + k < b.size()) d[8*k +: 8] = b[i + k];
      exp_q.push_back('{addr: dst + 16'(i), data: d});
    end
    exp_size = b.size();
  endtask

  task automatic run_frame(input logic [31:0] src, input logic [31:0] size,
                           input logic [31:0] dst, output int cycles);
    @(negedge clk);
    rle_addr = src; rle_size = size; message_addr = dst; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (done !== 1'b1 && cycles < BUDGET) begin
      @(posedge clk);
      #1 cycles++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: done not seen after %0d cycles, required done=1", cycles);
    end
  endtask

  task automatic test_reset;
    nreset = 1'b0; start = 1'b0;
    rle_addr = '0; rle_size = '0; message_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (port_a.port_A_we !== 1'b0 || port_a.port_A_addr !== 16'h0 ||
        port_a.port_A_data_in !== 32'h0 || done !== 1'b0 || message_size !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: got we %b addr %h din %h done %b size %0d, required all zero",
               port_a.port_A_we, port_a.port_A_addr, port_a.port_A_data_in, done, message_size);
    end
    @(negedge clk) nreset = 1'b1;
  endtask

  task automatic test_basic;
    int cyc;
    frame_w = '{32'h4203_4101};
    load_frame(16'h0100);
    build_expect(16'h0200, 1);
    run_frame(32'h0100, 32'd4, 32'h0200, cyc);
    n_checks++;
    if (cyc !== 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles, required 8", cyc);
    end
    n_checks++;
    if (message_size !== 32'd4) begin
      n_fail++;
      $display("FAIL basic_size: got %0d, required 4", message_size);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_writes: %0d expected writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_partial;
    int cyc;
    frame_w = '{32'h0000_5A05};
    load_frame(16'h0300);
    build_expect(16'h0400, 1);
    run_frame(32'h0300, 32'd4, 32'h0400, cyc);
    n_checks++;
    if (message_size !== 32'd5) begin
      n_fail++;
      $display("FAIL partial_size: got %0d, required 5", message_size);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL partial_writes: %0d expected writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_padding;
    int cyc;
    frame_w = '{32'h0000_0000, 32'h4301_4402};
    load_frame(16'h0500);
    build_expect(16'h0600, 2);
    run_frame(32'h0500, 32'd8, 32'h0600, cyc);
    n_checks++;
    if (message_size !== 32'd3) begin
      n_fail++;
      $display("FAIL padding_size: got %0d, required 3", message_size);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL padding_writes: %0d expected writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_size;
    int cyc;
    run_frame(32'h0700, 32'd0, 32'h0780, cyc);
    n_checks++;
    if (cyc > 1) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d cycles, required at most 1", cyc);
    end
    n_checks++;
    if (message_size !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_size: got %0d, required 0", message_size);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (port_a.port_A_we !== 1'b0 || port_a.port_A_addr !== 16'h0600) begin
      n_fail++;
      $display("FAIL zero_no_access: got we %b addr %h, required we 0 addr 0600",
               port_a.port_A_we, port_a.port_A_addr);
    end
  endtask

  task automatic test_long_run;
    int cyc;
    frame_w = '{32'h0000_FFFF};
    load_frame(16'h0800);
    build_expect(16'h1000, 1);
    run_frame(32'h0800, 32'd4, 32'h1000, cyc);
    n_checks++;
    if (message_size !== 32'd255) begin
      n_fail++;
      $display("FAIL long_size: got %0d, required 255", message_size);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL long_writes: %0d expected writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_busy_start;
    int cyc;
    frame_w = '{32'h4203_4101};
    build_expect(16'h0A00, 1);
    @(negedge clk);
    rle_addr = 32'h0100; rle_size = 32'd4; message_addr = 32'h0A00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rle_addr = 32'h0300; rle_size = 32'd8; message_addr = 32'h0B00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 4;
    while (done !== 1'b1 && cyc < BUDGET) begin
      @(posedge clk);
      #1 cyc++;
    end
    n_checks++;
    if (cyc !== 8) begin
      n_fail++;
      $display("FAIL busy_latency: got %0d cycles, required 8", cyc);
    end
    n_checks++;
    if (message_size !== 32'd4) begin
      n_fail++;
      $display("FAIL busy_size: got %0d, required 4", message_size);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL busy_writes: %0d expected writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    sb_ignore = 1'b1;
    @(negedge clk);
    rle_addr = 32'h0800; rle_size = 32'd4; message_addr = 32'h2000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk) nreset = 1'b0;
    #1;
    n_checks++;
    if (port_a.port_A_we !== 1'b0 || port_a.port_A_addr !== 16'h0 ||
        port_a.port_A_data_in !== 32'h0 || done !== 1'b0 || message_size !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_values: got we %b addr %h din %h done %b size %0d, required all zero",
               port_a.port_A_we, port_a.port_A_addr, port_a.port_A_data_in, done, message_size);
    end
    @(negedge clk) nreset = 1'b1;
    sb_ignore = 1'b0;
    exp_q.delete();
    frame_w = '{32'h0000_5A05};
    build_expect(16'h0C00, 1);
    run_frame(32'h0300, 32'd4, 32'h0C00, cyc);
    n_checks++;
    if (message_size !== 32'd5) begin
      n_fail++;
      $display("FAIL midreset_fresh_size: got %0d, required 5", message_size);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_fresh_writes: %0d expected writes missing, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_padding();
    test_zero_size();
    test_long_run();
    test_busy_start();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
